// File: rtl/msi_cache_ctrl.sv
// Direct-mapped write-back data cache controller with MSI snooping on a split bus.
// Define MSI_STATS_EN to add the saturating hit_cnt/miss_cnt outputs.
module msi_cache_ctrl #(
  parameter int LINES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pr_din,
  output logic [7:0]  pr_dout,
  input  logic [5:0]  pr_addr,
  input  logic        pr_rd,
  input  logic        pr_wr,
  output logic        pr_done,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  input  logic        bus_done_in,
  output logic        bus_done_out,
  input  logic        bus_grant,
  output logic        bus_request,
  input  logic [4:0]  bus_addr_in,
  output logic [4:0]  bus_addr_out,
  input  logic [2:0]  bus_op_in,
  output logic [2:0]  bus_op_out
`ifdef MSI_STATS_EN
  ,
  output logic [7:0]  hit_cnt,
  output logic [7:0]  miss_cnt
`endif
);

  // state       | meaning
  // Q_INITIAL   | one idle cycle after reset
  // Q_MONITOR   | serve snoops, then processor hits / dispatch misses
  // Q_FLUSH     | write back an M line requested by a remote BusRd/BusRdX
  // Q_WB        | write back the M victim before refilling
  // Q_BUS_RD    | read miss refill, line ends S
  // Q_BUS_RDX   | write miss refill, line ends M
  // Q_BUS_UPGR  | single-cycle upgrade S->M on a write hit
  typedef enum logic [6:0] {
    Q_INITIAL  = 7'b0000001,
    Q_MONITOR  = 7'b0000010,
    Q_FLUSH    = 7'b0000100,
    Q_WB       = 7'b0001000,
    Q_BUS_RD   = 7'b0010000,
    Q_BUS_RDX  = 7'b0100000,
    Q_BUS_UPGR = 7'b1000000
  } state_t;

  localparam int IW = $clog2(LINES);
  localparam int TW = 5 - IW;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_RD    = 3'b001;
  localparam logic [2:0] OP_UPGR  = 3'b010;
  localparam logic [2:0] OP_FLUSH = 3'b011;
  localparam logic [2:0] OP_RDX   = 3'b100;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b11;

  state_t state, state_nxt;

  logic [1:0]    msi_state [LINES];
  logic [TW-1:0] tag_q     [LINES];
  logic [15:0]   data_q    [LINES];

  logic [5:0]    req_addr;
  logic          req_wr;
  logic [7:0]    req_din;
  logic [IW-1:0] snp_idx;
  logic          snp_rdx;

  logic [IW-1:0] pr_idx, snp_idx_c, req_idx, fl_idx;
  logic [TW-1:0] pr_tag, snp_tag_c, req_tag;
  logic          pr_hit, snp_hit, snp_flush, snp_inv, accept, xfer_done;

  function automatic logic [7:0] get_byte(input logic [15:0] w, input logic sel);
    return sel ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [15:0] put_byte(input logic [15:0] w, input logic sel,
                                           input logic [7:0] b);
    return sel ? {b, w[7:0]} : {w[15:8], b};
  endfunction

  assign pr_idx    = pr_addr[IW:1];
  assign pr_tag    = pr_addr[5:IW+1];
  assign snp_idx_c = bus_addr_in[IW-1:0];
  assign snp_tag_c = bus_addr_in[4:IW];
  assign req_idx   = req_addr[IW:1];
  assign req_tag   = req_addr[5:IW+1];
  assign fl_idx    = (state == Q_WB) ? req_idx : snp_idx;
  assign xfer_done = bus_grant && bus_done_in;

  assign pr_hit  = (msi_state[pr_idx] != ST_I) && (tag_q[pr_idx] == pr_tag);
  assign snp_hit = (bus_op_in != OP_NONE) && (msi_state[snp_idx_c] != ST_I) &&
                   (tag_q[snp_idx_c] == snp_tag_c);
  assign snp_flush = snp_hit && (msi_state[snp_idx_c] == ST_M) &&
                     ((bus_op_in == OP_RD) || (bus_op_in == OP_RDX));
  assign snp_inv   = snp_hit && (msi_state[snp_idx_c] == ST_S) &&
                     ((bus_op_in == OP_RDX) || (bus_op_in == OP_UPGR));
  // pr_done masks the still-held request in the cycle the completion is reported
  assign accept = (state == Q_MONITOR) && (pr_rd || pr_wr) && !pr_done &&
                  !snp_flush && !snp_inv;

  always_comb begin
    state_nxt    = state;
    bus_request  = 1'b0;
    bus_op_out   = OP_NONE;
    bus_addr_out = '0;
    bus_dout     = '0;
    bus_done_out = 1'b0;
    case (state)
      Q_INITIAL: state_nxt = Q_MONITOR;
      Q_MONITOR: begin
        if (snp_flush) begin
          state_nxt = Q_FLUSH;
        end else if (accept) begin
          if (pr_hit) begin
            if (pr_wr && (msi_state[pr_idx] == ST_S)) state_nxt = Q_BUS_UPGR;
          end else if (msi_state[pr_idx] == ST_M) begin
            state_nxt = Q_WB;
          end else begin
            state_nxt = pr_wr ? Q_BUS_RDX : Q_BUS_RD;
          end
        end
      end
      Q_FLUSH, Q_WB: begin
        bus_request = 1'b1;
        if (bus_grant) begin
          bus_op_out   = OP_FLUSH;
          bus_addr_out = {tag_q[fl_idx], fl_idx};
          bus_dout     = data_q[fl_idx];
          if (bus_done_in) begin
            bus_done_out = 1'b1;
            if (state == Q_WB) state_nxt = req_wr ? Q_BUS_RDX : Q_BUS_RD;
            else               state_nxt = Q_MONITOR;
          end
        end
      end
      Q_BUS_RD, Q_BUS_RDX: begin
        bus_request = 1'b1;
        if (bus_grant) begin
          bus_op_out   = (state == Q_BUS_RD) ? OP_RD : OP_RDX;
          bus_addr_out = req_addr[5:1];
          if (bus_done_in) begin
            bus_done_out = 1'b1;
            state_nxt    = Q_MONITOR;
          end
        end
      end
      Q_BUS_UPGR: begin
        bus_request = 1'b1;
        if (bus_grant) begin
          bus_op_out   = OP_UPGR;
          bus_addr_out = req_addr[5:1];
          bus_done_out = 1'b1;
          state_nxt    = Q_MONITOR;
        end
      end
      default: state_nxt = Q_INITIAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= Q_INITIAL;
      pr_done  <= 1'b0;
      pr_dout  <= '0;
      req_addr <= '0;
      req_wr   <= 1'b0;
      req_din  <= '0;
      snp_idx  <= '0;
      snp_rdx  <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        msi_state[i] <= ST_I;
        tag_q[i]     <= '0;
        data_q[i]    <= '0;
      end
    end else begin
      state   <= state_nxt;
      pr_done <= 1'b0;
      case (state)
        Q_MONITOR: begin
          if (snp_flush) begin
            snp_idx <= snp_idx_c;
            snp_rdx <= (bus_op_in == OP_RDX);
          end else if (snp_inv) begin
            msi_state[snp_idx_c] <= ST_I;
          end else if (accept) begin
            req_addr <= pr_addr;
            req_wr   <= pr_wr;
            req_din  <= pr_din;
            if (pr_hit && !pr_wr) begin
              pr_dout <= get_byte(data_q[pr_idx], pr_addr[0]);
              pr_done <= 1'b1;
            end else if (pr_hit && (msi_state[pr_idx] == ST_M)) begin
              data_q[pr_idx] <= put_byte(data_q[pr_idx], pr_addr[0], pr_din);
              pr_done        <= 1'b1;
            end
          end
        end
        Q_FLUSH: if (xfer_done) msi_state[snp_idx] <= snp_rdx ? ST_I : ST_S;
        Q_WB:    if (xfer_done) msi_state[req_idx] <= ST_I;
        Q_BUS_RD, Q_BUS_RDX: begin
          if (xfer_done) begin
            tag_q[req_idx] <= req_tag;
            pr_done        <= 1'b1;
            if (state == Q_BUS_RD) begin
              data_q[req_idx]    <= bus_din;
              msi_state[req_idx] <= ST_S;
              pr_dout            <= get_byte(bus_din, req_addr[0]);
            end else begin
              data_q[req_idx]    <= put_byte(bus_din, req_addr[0], req_din);
              msi_state[req_idx] <= ST_M;
            end
          end
        end
        Q_BUS_UPGR: begin
          if (bus_grant) begin
            msi_state[req_idx] <= ST_M;
            data_q[req_idx]    <= put_byte(data_q[req_idx], req_addr[0], req_din);
            pr_done            <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MSI_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (pr_hit) begin
        if (hit_cnt != 8'hff) hit_cnt <= hit_cnt + 8'd1;
      end else if (miss_cnt != 8'hff) begin
        miss_cnt <= miss_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Bench for msi_cache_ctrl: vector table plus bus/processor scoreboards, memory and arbiter model.
module tb_msi_cache_ctrl;

  localparam logic [2:0] OP_NONE = 3'd0, OP_RD = 3'd1, OP_UPGR = 3'd2, OP_FLUSH = 3'd3, OP_RDX = 3'd4;
  localparam logic [1:0] K_SNP = 2'd0, K_RD = 2'd1, K_WR = 2'd2, K_BOTH = 2'd3;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [5:0]  addr;
    logic [7:0]  din;
    logic [2:0]  sop;
    logic [4:0]  saddr;
    logic [7:0]  exp_rd;
    int          nb;
    logic [2:0]  op0;
    logic [4:0]  a0;
    logic [15:0] d0;
    logic [2:0]  op1;
    logic [4:0]  a1;
    logic [15:0] d1;
    logic [1:0]  line;
    logic [1:0]  msi;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  addr;
    logic [15:0] data;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pr_din, pr_dout;
  logic [5:0]  pr_addr;
  logic        pr_rd, pr_wr, pr_done;
  logic [15:0] bus_din, bus_dout;
  logic        bus_done_in, bus_done_out, bus_grant, bus_request;
  logic [4:0]  bus_addr_in, bus_addr_out;
  logic [2:0]  bus_op_in, bus_op_out;
`ifdef MSI_STATS_EN
  logic [7:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  msi_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .pr_din(pr_din), .pr_dout(pr_dout), .pr_addr(pr_addr),
    .pr_rd(pr_rd), .pr_wr(pr_wr), .pr_done(pr_done),
    .bus_din(bus_din), .bus_dout(bus_dout),
    .bus_done_in(bus_done_in), .bus_done_out(bus_done_out),
    .bus_grant(bus_grant), .bus_request(bus_request),
    .bus_addr_in(bus_addr_in), .bus_addr_out(bus_addr_out),
    .bus_op_in(bus_op_in), .bus_op_out(bus_op_out)
`ifdef MSI_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Memory: 32x16, done one cycle after an op is presented. Arbiter: grant only on an idle bus.
  logic [15:0] mem [32];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      bus_grant   <= 1'b0;
      bus_done_in <= 1'b0;
      bus_din     <= '0;
      if (!loaded) begin
        for (int i = 0; i < 32; i++) mem[i] <= {8'h80 + 8'(i), 8'h40 + 8'(i)};
        loaded <= 1'b1;
      end
    end else begin
      bus_grant <= bus_request && !bus_done_out && (bus_op_in == OP_NONE);
      if ((bus_op_out == OP_RD || bus_op_out == OP_RDX || bus_op_out == OP_FLUSH) && !bus_done_in) begin
        bus_done_in <= 1'b1;
        bus_din     <= mem[bus_addr_out];
        if (bus_op_out == OP_FLUSH) mem[bus_addr_out] <= bus_dout;
      end else begin
        bus_done_in <= 1'b0;
      end
    end
  end

  int total = 0;
  int bad   = 0;
  bus_exp_t   bus_q[$];
  logic [8:0] pr_q[$];
  vec_t       vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bus_exp_t e;
    bit seen;
    if (v.nb > 0) begin e.op = v.op0; e.addr = v.a0; e.data = v.d0; bus_q.push_back(e); end
    if (v.nb > 1) begin e.op = v.op1; e.addr = v.a1; e.data = v.d1; bus_q.push_back(e); end
    if (v.kind == K_SNP) begin
      @(negedge clk);
      bus_op_in   = v.sop;
      bus_addr_in = v.saddr;
      @(negedge clk);
      bus_op_in   = OP_NONE;
      bus_addr_in = '0;
    end else begin
      pr_q.push_back({v.kind == K_RD, v.exp_rd});
      @(negedge clk);
      pr_addr = v.addr;
      pr_din  = v.din;
      pr_rd   = (v.kind == K_RD) || (v.kind == K_BOTH);
      pr_wr   = (v.kind == K_WR) || (v.kind == K_BOTH);
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk);
        if (pr_done) seen = 1'b1;
      end
      pr_rd = 1'b0;
      pr_wr = 1'b0;
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL pr_done_timeout vec=%0d actual=no_done required=done", idx);
      end
    end
    repeat (12) @(negedge clk);
    check($sformatf("bus_ops_left_v%0d", idx), bus_q.size(), 0);
    bus_q.delete();
    check($sformatf("line_state_v%0d", idx), dut.msi_state[v.line], v.msi);
  endtask

  initial begin
    bit got;
    vec_t v;
    rst = 1'b1; pr_din = '0; pr_addr = '0; pr_rd = 1'b0; pr_wr = 1'b0;
    bus_op_in = OP_NONE; bus_addr_in = '0;

    //          kind    addr   din     sop       saddr  exp_rd nb op0       a0     d0         op1     a1     d1     line  msi
    vecs[0]  = '{K_RD,  6'd1,  8'd0,  OP_NONE,  5'd0,  8'h80, 1, OP_RD,    5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd0, ST_S};
    vecs[1]  = '{K_WR,  6'd9,  8'd12, OP_NONE,  5'd0,  8'h00, 1, OP_RDX,   5'd4,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd0, ST_M};
    vecs[2]  = '{K_RD,  6'd8,  8'd0,  OP_NONE,  5'd0,  8'h44, 0, OP_NONE,  5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd0, ST_M};
    vecs[3]  = '{K_SNP, 6'd0,  8'd0,  OP_RD,    5'd0,  8'h00, 0, OP_NONE,  5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd0, ST_M};
    vecs[4]  = '{K_SNP, 6'd0,  8'd0,  OP_RD,    5'd4,  8'h00, 1, OP_FLUSH, 5'd4,  16'h0C44, OP_NONE, 5'd0, 16'h0, 2'd0, ST_S};
    vecs[5]  = '{K_WR,  6'd9,  8'd13, OP_NONE,  5'd0,  8'h00, 1, OP_UPGR,  5'd4,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd0, ST_M};
    vecs[6]  = '{K_WR,  6'd1,  8'd14, OP_NONE,  5'd0,  8'h00, 2, OP_FLUSH, 5'd4,  16'h0D44, OP_RDX,  5'd0, 16'h0, 2'd0, ST_M};
    vecs[7]  = '{K_SNP, 6'd0,  8'd0,  OP_RDX,   5'd0,  8'h00, 1, OP_FLUSH, 5'd0,  16'h0E40, OP_NONE, 5'd0, 16'h0, 2'd0, ST_I};
    vecs[8]  = '{K_RD,  6'd9,  8'd0,  OP_NONE,  5'd0,  8'h0D, 1, OP_RD,    5'd4,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd0, ST_S};
    vecs[9]  = '{K_RD,  6'd9,  8'd0,  OP_NONE,  5'd0,  8'h0D, 0, OP_NONE,  5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd0, ST_S};
    vecs[10] = '{K_SNP, 6'd0,  8'd0,  OP_RDX,   5'd4,  8'h00, 0, OP_NONE,  5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd0, ST_I};
    vecs[11] = '{K_RD,  6'd3,  8'd0,  OP_NONE,  5'd0,  8'h81, 1, OP_RD,    5'd1,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd1, ST_S};
    vecs[12] = '{K_RD,  6'd2,  8'd0,  OP_NONE,  5'd0,  8'h41, 0, OP_NONE,  5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd1, ST_S};
    vecs[13] = '{K_SNP, 6'd0,  8'd0,  OP_RD,    5'd1,  8'h00, 0, OP_NONE,  5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd1, ST_S};
    vecs[14] = '{K_SNP, 6'd0,  8'd0,  OP_UPGR,  5'd1,  8'h00, 0, OP_NONE,  5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd1, ST_I};
    vecs[15] = '{K_BOTH,6'd4,  8'h55, OP_NONE,  5'd0,  8'h00, 1, OP_RDX,   5'd2,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd2, ST_M};
    vecs[16] = '{K_SNP, 6'd0,  8'd0,  OP_RD,    5'd2,  8'h00, 1, OP_FLUSH, 5'd2,  16'h8255, OP_NONE, 5'd0, 16'h0, 2'd2, ST_S};
    vecs[17] = '{K_RD,  6'd4,  8'd0,  OP_NONE,  5'd0,  8'h55, 0, OP_NONE,  5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd2, ST_S};
    vecs[18] = '{K_RD,  6'd5,  8'd0,  OP_NONE,  5'd0,  8'h82, 0, OP_NONE,  5'd0,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd2, ST_S};
    vecs[19] = '{K_WR,  6'd6,  8'h77, OP_NONE,  5'd0,  8'h00, 1, OP_RDX,   5'd3,  16'h0000, OP_NONE, 5'd0, 16'h0, 2'd3, ST_M};
    vecs[20] = '{K_RD,  6'd14, 8'd0,  OP_NONE,  5'd0,  8'h47, 2, OP_FLUSH, 5'd3,  16'h8377, OP_RD,   5'd7, 16'h0, 2'd3, ST_S};

    // Bus and processor completion monitor
    fork
      begin
        bus_exp_t e;
        logic [8:0] p;
        forever begin
          @(negedge clk);
          if (!rst && bus_done_out) begin
            if (bus_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL bus_unexpected actual=op%0d@%0d required=no_op", bus_op_out, bus_addr_out);
            end else begin
              e = bus_q.pop_front();
              check("bus_op", bus_op_out, e.op);
              check("bus_addr", bus_addr_out, e.addr);
              if (e.op == OP_FLUSH) check("bus_flush_data", bus_dout, e.data);
            end
          end
          if (!rst && pr_done) begin
            if (pr_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL pr_done_unexpected actual=1 required=0");
            end else begin
              p = pr_q.pop_front();
              if (p[8]) check("pr_dout", pr_dout, p[7:0]);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_state", dut.state, 7'b0000001);
    check("rst_pr_done", pr_done, 0);
    check("rst_pr_dout", pr_dout, 0);
    check("rst_bus_request", bus_request, 0);
    check("rst_bus_op", bus_op_out, OP_NONE);
    check("rst_bus_addr", bus_addr_out, 0);
    check("rst_bus_done_out", bus_done_out, 0);
    check("rst_bus_dout", bus_dout, 0);
    rst = 1'b0;
    @(negedge clk);
    check("state_monitor", dut.state, 7'b0000010);

    for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

`ifdef MSI_STATS_EN
    check("hit_cnt", hit_cnt, 6);
    check("miss_cnt", miss_cnt, 8);
`endif

    // Reset while a read miss is waiting for the bus
    @(negedge clk);
    pr_addr = 6'd6;
    pr_rd   = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus_request) got = 1'b1;
    end
    check("midrst_request_seen", got, 1);
    rst = 1'b1;
    @(negedge clk);
    pr_rd = 1'b0;
    check("midrst_request_dropped", bus_request, 0);
    check("midrst_state", dut.state, 7'b0000001);
    for (int l = 0; l < 4; l++) check($sformatf("midrst_line%0d", l), dut.msi_state[l], ST_I);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Memory kept the flushed line across the controller reset
    v = '{K_RD, 6'd6, 8'd0, OP_NONE, 5'd0, 8'h77, 1, OP_RD, 5'd3, 16'h0000, OP_NONE, 5'd0, 16'h0, 2'd3, ST_S};
    run_vec(21, v);
`ifdef MSI_STATS_EN
    check("miss_cnt_after_rst", miss_cnt, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msi_cache_ctrl.md
Name: msi_cache_ctrl

Overview:
- Per-core, direct-mapped, write-back data cache controller implementing the MSI snooping coherence protocol on a shared split bus.
- Serves byte reads and writes from the processor and snoops remote bus operations.
- Obtains bus ownership through a request/grant arbiter and moves whole 16-bit blocks to and from a word-addressed backing memory.

Parameters:
- LINES, 4, number of cache lines; index = pr_addr[2:1], tag = pr_addr[5:3].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- pr_din  in  8  processor write byte
- pr_dout  out  8  processor read byte
- pr_addr  in  6  byte address; [5:1] = block, [0] = byte select (0 selects bits [7:0])
- pr_rd  in  1  read request, held until pr_done
- pr_wr  in  1  write request, held until pr_done
- pr_done  out  1  one-cycle completion pulse
- bus_din  in  16  block data from memory
- bus_dout  out  16  block data driven on Flush
- bus_done_in  in  1  memory completed the current Rd/RdX/Flush
- bus_done_out  out  1  own bus transaction finished; arbiter releases grant
- bus_grant  in  1  bus ownership
- bus_request  out  1  bus ownership request
- bus_addr_in  in  5  snooped block address
- bus_addr_out  out  5  block address of own transaction
- bus_op_in  in  3  snooped op
- bus_op_out  out  3  own op: None=000, Rd=001, Upgr=010, Flush=011, RdX=100

Behaviour:
- Line state: 2-bit msi_state per line, I=00, S=01, M=11.
- FSM state: 7-bit one-hot `state`: QInitial=0000001, QMonitor=0000010, QFlush=0000100, QWB=0001000, QBusRd=0010000, QBusRdX=0100000, QBusUpgr=1000000.
- Reset: all lines I, tags/data 0, state=QInitial, all outputs 0 (bus_op_out=None). Next cycle QInitial->QMonitor.
- Bus drive: bus_op_out and bus_addr_out are driven only while bus_grant=1 in a bus state; otherwise None/0.
- bus_request: asserted from entry to a bus state until bus_done_out.
- Snoop priority in QMonitor: bus_op_in != None with matching tag and valid line is serviced before any processor request.
  - BusRd hitting M: QFlush.
  - BusRdX hitting M: QFlush.
  - BusRdX or BusUpgr hitting S: line -> I the same cycle.
  - BusRd hitting S: no action.
  - Miss or I line: no action.
- QFlush: request the bus; on grant drive Flush with line data on bus_dout.
  - On bus_done_in: pulse bus_done_out.
  - Line goes M->S for BusRd, M->I for BusRdX.
  - Return to QMonitor.
- Processor read hit (S or M): pr_dout = selected byte, pr_done pulses the next cycle, no bus activity.
- Processor write hit on M: byte written, pr_done.
- Processor write hit on S: QBusUpgr. On grant drive Upgr for one cycle with bus_done_out=1, no memory wait. Line S->M, byte written, pr_done.
- Miss with victim M: QWB flushes the victim (as QFlush, using the victim's tag address); victim -> I; then proceed as a clean miss.
- Clean read miss: QBusRd drives Rd. On bus_done_in: load bus_din, tag, S; assert bus_done_out and pr_done; pr_dout = requested byte.
- Clean write miss: QBusRdX drives RdX. On bus_done_in: load bus_din merged with pr_din, state M; assert bus_done_out and pr_done.
- While in a bus state, snoops are ignored; the arbiter only grants when bus_op_in=None.
- Simultaneous pr_rd and pr_wr: write wins.
- rst mid-transaction: abort, drop bus_request, all lines I.
- Memory model (bench side): 32x16 words, preloaded. Read returns a word, write stores bus_dout. mem_done pulses 1 cycle after the op is presented.

Optional Feature:
- Macro MSI_STATS_EN.
- When defined: adds outputs hit_cnt[7:0] and miss_cnt[7:0], counting processor hits and misses.
  - Saturating at 255.
  - Cleared by rst.
- When undefined: ports are absent and behaviour is otherwise identical.

Test Plan:
- Read @1 from reset -> Rd at block 0; line0 I->S; pr_done; pr_dout = mem[0][15:8].
- Write 12@9 (line0 S, tag differs, clean) -> RdX at block 4; line0 M with byte [15:8]=12; no Flush.
- Snoop BusRd block 0 (tag miss) -> no bus op. Snoop BusRd block 4 -> Flush at addr 4 with data holding 12; line0 M->S.
- Write 13@9 on S -> one Upgr cycle, line0 M. Write 14@1 -> Flush block 4 (13 to mem), then RdX block 0, line0 M. Snoop BusRdX block 0 -> Flush, line0 I.
- Read @9 -> Rd, S, pr_dout=13. Read @9 again -> hit, no bus op. Snoop BusRdX block 4 -> line0 S->I, no Flush.
- Read @3 -> line1 S. Read @2 -> hit. Snoop BusRd block 1 -> stays S. Snoop BusUpgr block 1 -> line1 I.
